// File: rtl/moller_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : moller_stream_packer
// Brief    : Selects two ADC channels, decimates them, prepends a header and
//            buffers framed 64-bit words in an FWFT FIFO towards AXI4-Stream.
// Revision : 1.0 - initial release
// ============================================================================
module moller_stream_packer #(
   parameter int SAMPLE_WIDTH = 18,
   parameter int NUM_CH       = 16,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                           axi_aclk,
   input  logic                           axi_aresetn,
   input  logic [NUM_CH*SAMPLE_WIDTH-1:0] adc_data,
   input  logic                           adc_valid,
   input  logic                           enable,
   input  logic [3:0]                     ch0,
   input  logic [3:0]                     ch1,
   input  logic [6:0]                     rate_div,
   input  logic [15:0]                    num_samples,
   input  logic                           clear_counters,
   output logic [63:0]                    m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast,
   output logic                           busy,
   output logic [15:0]                    overflow_count
);

   localparam int          c_addr_w = $clog2(FIFO_DEPTH);
   localparam logic [15:0] c_magic  = 16'h4D4C;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HEADER = 2'd1,
      S_DATA   = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [3:0]  r_ch0;
   logic [3:0]  r_ch1;
   logic [6:0]  r_rate_div;
   logic [15:0] r_num_samples;
   logic [6:0]  r_dcnt;
   logic [15:0] r_wcnt;
   logic [15:0] r_seq;
   logic [15:0] r_overflow;
   logic        r_busy;

   logic [64:0]       r_mem [FIFO_DEPTH];
   logic [c_addr_w:0] r_wptr;
   logic [c_addr_w:0] r_rptr;
   logic [c_addr_w:0] w_count;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic [64:0]       w_head;

   logic              w_wr_req;
   logic [64:0]       w_din;
   logic              w_take;
   logic              w_last;
   logic [31:0]       w_ext0;
   logic [31:0]       w_ext1;

   logic [SAMPLE_WIDTH-1:0] w_ch [NUM_CH];

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign w_ch[k] = adc_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
   end

   assign w_ext0 = 32'($signed(w_ch[r_ch0]));
   assign w_ext1 = 32'($signed(w_ch[r_ch1]));
   assign w_last = (r_wcnt == r_num_samples - 16'd1);

   // Full is judged on the pre-read occupancy, so a write in a full cycle is lost
   assign w_count = r_wptr - r_rptr;
   assign w_full  = (w_count == (c_addr_w+1)'(FIFO_DEPTH));
   assign w_empty = (r_wptr == r_rptr);
   assign w_push  = w_wr_req && !w_full;
   assign w_pop   = !w_empty && m_axis_tready;
   assign w_head  = r_mem[r_rptr[c_addr_w-1:0]];

   assign m_axis_tvalid  = !w_empty;
   assign m_axis_tdata   = w_empty ? 64'd0 : w_head[63:0];
   assign m_axis_tlast   = !w_empty && w_head[64];
   assign busy           = r_busy;
   assign overflow_count = r_overflow;

   always_comb begin
      w_state_nxt = r_state;
      w_wr_req    = 1'b0;
      w_din       = '0;
      w_take      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable && (num_samples != 16'd0))
               w_state_nxt = S_HEADER;
         end
         S_HEADER: begin
            w_wr_req = 1'b1;
            w_din    = {1'b0, c_magic, r_seq, r_num_samples, r_ch1, r_ch0, 1'b0, r_rate_div};
            if (!w_full)
               w_state_nxt = S_DATA;
         end
         S_DATA: begin
            if (adc_valid && (r_dcnt == 7'd0)) begin
               w_take   = 1'b1;
               w_wr_req = 1'b1;
               w_din    = {w_last, w_ext1, w_ext0};
               if (!w_full && w_last)
                  w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_state       <= S_IDLE;
         r_busy        <= 1'b0;
         r_ch0         <= '0;
         r_ch1         <= '0;
         r_rate_div    <= '0;
         r_num_samples <= '0;
         r_dcnt        <= '0;
         r_wcnt        <= '0;
         r_seq         <= '0;
         r_overflow    <= '0;
         r_wptr        <= '0;
         r_rptr        <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         if ((r_state == S_IDLE) && (w_state_nxt == S_HEADER)) begin
            r_ch0         <= ch0;
            r_ch1         <= ch1;
            r_rate_div    <= rate_div;
            r_num_samples <= num_samples;
            r_dcnt        <= '0;
            r_wcnt        <= '0;
         end
         if ((r_state == S_DATA) && adc_valid) begin
            if (r_dcnt != 7'd0)
               r_dcnt <= r_dcnt - 7'd1;
            else
               r_dcnt <= r_rate_div;
         end
         if (w_take && !w_full) begin
            r_wcnt <= r_wcnt + 16'd1;
            if (w_last)
               r_seq <= r_seq + 16'd1;
         end
         if (clear_counters)
            r_overflow <= '0;
         else if (w_take && w_full && (r_overflow != 16'hFFFF))
            r_overflow <= r_overflow + 16'd1;
         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (w_push)
         r_mem[r_wptr[c_addr_w-1:0]] <= w_din;
   end

endmodule
`default_nettype wire

// File: tb/tb_moller_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_moller_stream_packer
// Brief    : Directed self-checking bench for moller_stream_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_moller_stream_packer;

   localparam int SW  = 18;
   localparam int NCH = 16;

   logic              axi_aclk = 1'b0;
   logic              axi_aresetn = 1'b0;
   logic [NCH*SW-1:0] adc_data = '0;
   logic              adc_valid = 1'b0;
   logic              enable = 1'b0;
   logic [3:0]        ch0 = 4'd2;
   logic [3:0]        ch1 = 4'd5;
   logic [6:0]        rate_div = 7'd0;
   logic [15:0]       num_samples = 16'd4;
   logic              clear_counters = 1'b0;
   logic [63:0]       m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready = 1'b1;
   logic              m_axis_tlast;
   logic              busy;
   logic [15:0]       overflow_count;

   int n_checks = 0;
   int n_err    = 0;

   logic [63:0] q_data [$];
   logic        q_last [$];

   moller_stream_packer #(
      .SAMPLE_WIDTH (SW),
      .NUM_CH       (NCH),
      .FIFO_DEPTH   (16)
   ) dut (
      .axi_aclk       (axi_aclk),
      .axi_aresetn    (axi_aresetn),
      .adc_data       (adc_data),
      .adc_valid      (adc_valid),
      .enable         (enable),
      .ch0            (ch0),
      .ch1            (ch1),
      .rate_div       (rate_div),
      .num_samples    (num_samples),
      .clear_counters (clear_counters),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tlast   (m_axis_tlast),
      .busy           (busy),
      .overflow_count (overflow_count)
   );

   always #5 axi_aclk = ~axi_aclk;

   // Inputs change 1 unit after rising edges, so a handshake seen here completes on the next edge
   always @(negedge axi_aclk) begin
      if (axi_aresetn && m_axis_tvalid && m_axis_tready) begin
         q_data.push_back(m_axis_tdata);
         q_last.push_back(m_axis_tlast);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge axi_aclk);
      #1;
   endtask

   task automatic fill(input logic [SW-1:0] v2, input logic [SW-1:0] v5);
      for (int k = 0; k < NCH; k++)
         adc_data[k*SW +: SW] = SW'(k + 'h100);
      adc_data[2*SW +: SW] = v2;
      adc_data[5*SW +: SW] = v5;
   endtask

   task automatic pulse_en();
      enable = 1'b1;
      tick(1);
      enable = 1'b0;
   endtask

   initial begin
      int n_last;
      fill(18'h102, 18'h105);
      tick(3);
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_tdata", m_axis_tdata, 64'd0);
      chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ovf", 64'(overflow_count), 64'd0);
      axi_aresetn = 1'b1;
      tick(2);

      // Basic frame, strobe every cycle
      adc_valid = 1'b1;
      q_data.delete(); q_last.delete();
      pulse_en();
      chk("t1_busy_rise", 64'(busy), 64'd1);
      tick(15);
      chk("t1_size", 64'(q_data.size()), 64'd5);
      chk("t1_hdr", q_data[0], 64'h4D4C_0000_0004_5200);
      for (int i = 1; i < 5; i++)
         chk("t1_data", q_data[i], 64'h0000_0105_0000_0102);
      for (int i = 0; i < 5; i++)
         chk("t1_last", 64'(q_last[i]), (i == 4) ? 64'd1 : 64'd0);
      chk("t1_busy_fall", 64'(busy), 64'd0);

      q_data.delete(); q_last.delete();
      pulse_en();
      tick(15);
      chk("t1b_size", 64'(q_data.size()), 64'd5);
      chk("t1b_hdr_seq1", q_data[0], 64'h4D4C_0001_0004_5200);
      chk("t1b_last", 64'(q_last[4]), 64'd1);

      // Sign extension of channel 2
      fill(18'h20000, 18'h105);
      num_samples = 16'd1;
      q_data.delete(); q_last.delete();
      pulse_en();
      tick(10);
      chk("t2_size", 64'(q_data.size()), 64'd2);
      chk("t2_hdr", q_data[0], 64'h4D4C_0002_0001_5200);
      chk("t2_data", q_data[1], 64'h0000_0105_FFFE_0000);
      chk("t2_last", 64'(q_last[1]), 64'd1);

      // Decimation: 12 strobes in DATA, keep 1, 5, 9
      adc_valid   = 1'b0;
      rate_div    = 7'd3;
      num_samples = 16'd3;
      q_data.delete(); q_last.delete();
      pulse_en();
      tick(1);
      for (int i = 1; i <= 12; i++) begin
         fill(SW'(i), SW'('h100 + i));
         adc_valid = 1'b1;
         tick(1);
      end
      adc_valid = 1'b0;
      tick(5);
      chk("t3_size", 64'(q_data.size()), 64'd4);
      chk("t3_hdr", q_data[0], 64'h4D4C_0003_0003_5203);
      chk("t3_d1", q_data[1], 64'h0000_0101_0000_0001);
      chk("t3_d5", q_data[2], 64'h0000_0105_0000_0005);
      chk("t3_d9", q_data[3], 64'h0000_0109_0000_0009);
      chk("t3_last", 64'(q_last[3]), 64'd1);
      chk("t3_notlast", 64'(q_last[2]), 64'd0);

      // Overflow with tready low
      fill(18'h102, 18'h105);
      rate_div      = 7'd0;
      num_samples   = 16'd100;
      m_axis_tready = 1'b0;
      q_data.delete(); q_last.delete();
      pulse_en();
      adc_valid = 1'b1;
      tick(30);
      adc_valid = 1'b0;
      chk("t4_ovf", 64'(overflow_count), 64'd14);
      chk("t4_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("t4_hold_hdr", m_axis_tdata, 64'h4D4C_0004_0064_5200);
      chk("t4_busy", 64'(busy), 64'd1);
      m_axis_tready = 1'b1;
      tick(4);
      adc_valid = 1'b1;
      tick(120);
      adc_valid = 1'b0;
      tick(20);
      chk("t4_size", 64'(q_data.size()), 64'd101);
      chk("t4_hdr", q_data[0], 64'h4D4C_0004_0064_5200);
      chk("t4_last_pos", 64'(q_last[100]), 64'd1);
      n_last = 0;
      foreach (q_last[i]) if (q_last[i]) n_last++;
      chk("t4_last_cnt", 64'(n_last), 64'd1);
      chk("t4_ovf_kept", 64'(overflow_count), 64'd14);
      clear_counters = 1'b1;
      tick(1);
      chk("t4_clr", 64'(overflow_count), 64'd0);
      clear_counters = 1'b0;
      tick(1);
      chk("t4_clr_after", 64'(overflow_count), 64'd0);

      // Enable dropped after two data words
      num_samples = 16'd4;
      q_data.delete(); q_last.delete();
      enable = 1'b1;
      tick(2);
      adc_valid = 1'b1;
      tick(2);
      enable = 1'b0;
      tick(10);
      adc_valid = 1'b0;
      chk("t5_size", 64'(q_data.size()), 64'd5);
      chk("t5_hdr", q_data[0], 64'h4D4C_0005_0004_5200);
      chk("t5_last", 64'(q_last[4]), 64'd1);
      tick(10);
      chk("t5_no_new", 64'(q_data.size()), 64'd5);
      chk("t5_busy", 64'(busy), 64'd0);

      // Asynchronous reset mid-frame
      m_axis_tready = 1'b0;
      pulse_en();
      adc_valid = 1'b1;
      tick(3);
      chk("t6_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("t6_pre_busy", 64'(busy), 64'd1);
      #2;
      axi_aresetn = 1'b0;
      #1;
      chk("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_tdata", m_axis_tdata, 64'd0);
      adc_valid = 1'b0;
      tick(1);
      axi_aresetn = 1'b1;
      tick(2);
      chk("t6_empty", 64'(m_axis_tvalid), 64'd0);
      m_axis_tready = 1'b1;
      q_data.delete(); q_last.delete();
      pulse_en();
      adc_valid = 1'b1;
      tick(12);
      adc_valid = 1'b0;
      chk("t6_size", 64'(q_data.size()), 64'd5);
      chk("t6_hdr_seq0", q_data[0], 64'h4D4C_0000_0004_5200);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/moller_stream_packer.md
# moller_stream_packer

Consumes the 16-channel parallel ADC sample bus and produces framed AXI4-Stream output for the host data path. It is configured directly by the `stream_ctrl` register fields `enable`, `ch0`, `ch1`, `rate_div` and `num_samples`. It selects two channels, decimates them, prepends a header, and buffers words in a small FIFO against downstream backpressure. Its overflow counter feeds a read-only status register, cleared by `adc_ctrl.clear_counters`.

## Interface

Parameters:
- `SAMPLE_WIDTH`, default 18: signed ADC sample width.
- `NUM_CH`, default 16: channels on `adc_data`.
- `FIFO_DEPTH`, default 16: output FIFO depth in 64-bit words. Must be a power of 2 and ≥ 4.

Ports:
- `axi_aclk`  in  1: the block's single clock.
- `axi_aresetn`  in  1: asynchronous, active-low reset.
- `adc_data`  in  NUM_CH*SAMPLE_WIDTH: channel k occupies bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- `adc_valid`  in  1: one-cycle strobe marking a new simultaneous sample set.
- `enable`  in  1: `stream_ctrl.enable`.
- `ch0`  in  4: `stream_ctrl.ch0`.
- `ch1`  in  4: `stream_ctrl.ch1`.
- `rate_div`  in  7: `stream_ctrl.rate_div`.
- `num_samples`  in  16: `stream_ctrl.num_samples`.
- `clear_counters`  in  1: level; while high, holds `overflow_count` at 0.
- `m_axis_tdata`  out  64: stream data.
- `m_axis_tvalid`  out  1: stream valid.
- `m_axis_tready`  in  1: stream ready.
- `m_axis_tlast`  out  1: marks the last word of a frame.
- `busy`  out  1: high while a frame is in progress (HEADER or DATA state).
- `overflow_count`  out  16: saturating count of dropped sample sets.

## Operation

State machine: IDLE, HEADER, DATA.

- **IDLE**
  - Condition to leave: `enable`=1 and `num_samples`≠0.
  - On leaving: latch `ch0`, `ch1`, `rate_div`, `num_samples`; clear the decimation counter `dcnt` to 0; clear the word counter `wcnt` to 0; go to HEADER.
  - If `num_samples`=0, no frame is ever started.
- **HEADER**
  - On the first cycle with the FIFO not full, write the header word and go to DATA.
  - `adc_valid` is ignored in this state (not counted, not dropped).
  - Header word layout: [63:48]=16'h4D4C, [47:32]=`seq`, [31:16]=latched `num_samples`, [15:12]=`ch1`, [11:8]=`ch0`, [7]=0, [6:0]=`rate_div`.
  - `tlast`=0 on the header word.
- **DATA**
  - On each `adc_valid`:
    - If `dcnt`≠0: decrement `dcnt`.
    - If `dcnt`=0: reload `dcnt` to `rate_div`, then take the sample set.
  - Taking a sample set:
    - FIFO not full: write data word [63:32]=sign-extended sample `ch1`, [31:0]=sign-extended sample `ch0`; increment `wcnt`.
    - FIFO full: drop the set and increment `overflow_count` (saturates at 16'hFFFF). `wcnt` is not incremented, so every frame always carries exactly `num_samples` data words.
  - The word written when `wcnt`=`num_samples`-1 carries `tlast`=1. On that write, `seq` increments (16-bit, wraps 16'hFFFF→0) and the state returns to IDLE.
  - Net effect: one set in every `rate_div`+1 strobes is kept. The first strobe in DATA is always kept.
- **Enable deassert mid-frame:** the current frame completes normally; no new frame starts. Config changes mid-frame are ignored until the next IDLE exit.
- **FIFO:**
  - First-word-fall-through; `tlast` is stored alongside `tdata` (65-bit entries).
  - Output follows standard AXIS rules: `tdata`/`tlast` hold stable while `tvalid`=1 and `tready`=0.
  - A simultaneous read and write when full is not allowed: the full flag is evaluated before the read, and a write against it is dropped.
- **Counter clear:** if `clear_counters` and an overflow occur in the same cycle, the clear wins and `overflow_count`=0.

## Timing

- Reset values: state=IDLE, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy`=0, `overflow_count`=0, `seq`=0, FIFO empty.
- IDLE→HEADER takes 1 cycle after `enable` is seen. The header is written at the end of the first HEADER cycle when the FIFO is not full.
- A sample set accepted on cycle N with the FIFO empty appears on `m_axis` with `tvalid`=1 in cycle N+1.
- With `tready` held at 1, throughput is one word per cycle.
- After the last data word's write, the block is back in IDLE on the next cycle. A new header is written no earlier than 2 cycles later.
- `busy` is registered: it rises the cycle after IDLE exit and falls the cycle after the `tlast` word is written.

## Test plan

- **Basic frame:** `rate_div`=0, `num_samples`=4, `ch0`=2, `ch1`=5, `tready`=1. Drive channel k with value k+0x100 and `adc_valid` every cycle.
  - Required: header 0x4D4C_0000_0004_5200, then 4× 0x0000_0105_0000_0102; `tlast` on word 5 only; next header shows `seq`=1.
- **Sign extension:** ch0 sample = 18'h20000.
  - Required: [31:0]=0xFFFE_0000.
- **Decimation:** `rate_div`=3, `num_samples`=3, 12 strobes.
  - Required: sets from strobes 1, 5, 9 only; strobes 2–4, 6–8, 10–12 produce no words.
- **Overflow:** `FIFO_DEPTH`=16, `tready`=0, `num_samples`=100, strobe every cycle for 30 cycles.
  - Required: 16 words held in the FIFO; `overflow_count`=14 (the header slot is taken before DATA).
  - Release `tready`: the frame still totals 100 data words with one `tlast`.
  - Pulse `clear_counters`: `overflow_count`=0.
- **Enable drop and reset:**
  - Drop `enable` after 2 of 4 data words: the frame completes with 4 words, then no new header appears.
  - Assert `axi_aresetn`=0 mid-frame: `tvalid`=0, `busy`=0, `seq`=0 immediately, and the FIFO is emptied.
